// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from hsync/vsync, checks
// 640x480@60 timing, builds a per-frame rotate-XOR checksum and tracks lock state.
module vga_rx_monitor #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic [11:0] px_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic        locked,
  output logic [3:0]  err
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_OFF = H_SYNC + H_BP;
  localparam int V_OFF = V_SYNC + V_BP;

  typedef enum logic [1:0] {HUNT, SYNCED, LOCKED} state_t;

  state_t      state, state_n;
  logic [3:0]  clean_cnt, clean_n, clean_inc;
  logic        frame_bad, bad_n, publish;

  logic        hs_prev, vs_prev;
  logic [11:0] h_cnt, hs_w;
  logic [10:0] v_cnt, vs_w;
  logic [15:0] run_sum;

  logic        h_fall, h_rise, v_fall, v_rise;
  logic [11:0] h_cur;
  logic [12:0] line_len;
  logic [10:0] v_lines, v_cur;
  logic [3:0]  mis, flag;
  logic        capture;
  logic [11:0] rgb;
  logic [15:0] sum_next;

  assign h_fall = pix_ce & hs_prev & ~hsync;
  assign h_rise = pix_ce & ~hs_prev & hsync;
  assign v_fall = pix_ce & vs_prev & ~vsync;
  assign v_rise = pix_ce & ~vs_prev & vsync;

  // Position of the current sample; the hsync edge is applied before the vsync edge.
  assign h_cur    = h_fall ? 12'd0 : ((&h_cnt) ? h_cnt : h_cnt + 12'd1);
  assign line_len = {1'b0, h_cnt} + 13'd1;
  assign v_lines  = (h_fall && !(&v_cnt)) ? v_cnt + 11'd1 : v_cnt;
  assign v_cur    = v_fall ? 11'd0 : v_lines;

  assign mis = {v_rise && (vs_w != 11'(V_SYNC)),
                v_fall && (v_lines != 11'(V_TOT)),
                h_rise && (hs_w != 12'(H_SYNC)),
                h_fall && (line_len != 13'(H_TOT))};
  assign flag = (state == HUNT) ? 4'd0 : mis;

  assign capture = pix_ce && (state != HUNT) &&
                   (h_cur >= 12'(H_OFF)) && (h_cur < 12'(H_OFF + H_VIS)) &&
                   (v_cur >= 11'(V_OFF)) && (v_cur < 11'(V_OFF + V_VIS));

  assign rgb       = {red, green, blue};
  assign sum_next  = {run_sum[14:0], run_sum[15]} ^ {4'd0, rgb};
  assign clean_inc = clean_cnt + 4'd1;
  assign locked    = (state == LOCKED);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      clean_cnt <= 4'd0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_n;
      clean_cnt <= clean_n;
      frame_bad <= bad_n;
    end
  end

  // A frame counts as clean only if no mismatch occurred up to and including its closing edge.
  always_comb begin
    state_n = state;
    clean_n = clean_cnt;
    bad_n   = frame_bad;
    publish = 1'b0;
    if (pix_ce) begin
      if (state == HUNT) begin
        if (v_fall) begin
          state_n = SYNCED;
          clean_n = 4'd0;
          bad_n   = 1'b0;
        end
      end else begin
        if (|flag) begin
          bad_n   = 1'b1;
          clean_n = 4'd0;
          if (state == LOCKED) state_n = SYNCED;
        end
        if (v_fall) begin
          publish = 1'b1;
          bad_n   = 1'b0;
          if (state == SYNCED && !frame_bad && !(|flag)) begin
            if (clean_inc >= 4'(LOCK_FRAMES)) begin
              state_n = LOCKED;
              clean_n = 4'd0;
            end else begin
              clean_n = clean_inc;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      h_cnt      <= 12'd0;
      hs_w       <= 12'd0;
      v_cnt      <= 11'd0;
      vs_w       <= 11'd0;
      run_sum    <= 16'd0;
      px_valid   <= 1'b0;
      px_x       <= 10'd0;
      px_y       <= 9'd0;
      px_rgb     <= 12'd0;
      frame_done <= 1'b0;
      frame_sum  <= 16'd0;
      frame_cnt  <= 16'd0;
      err        <= 4'd0;
    end else begin
      px_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (pix_ce) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
        h_cnt   <= h_cur;
        v_cnt   <= v_cur;
        err     <= err | flag;
        if (h_fall)
          hs_w <= 12'd1;
        else if (!hsync && !(&hs_w))
          hs_w <= hs_w + 12'd1;
        // vsync width is measured in lines, so it only advances on hsync falls.
        if (v_fall)
          vs_w <= 11'd1;
        else if (h_fall && !vsync && !(&vs_w))
          vs_w <= vs_w + 11'd1;
        if (capture) begin
          px_valid <= 1'b1;
          px_x     <= 10'(h_cur - 12'(H_OFF));
          px_y     <= 9'(v_cur - 11'(V_OFF));
          px_rgb   <= rgb;
          run_sum  <= sum_next;
        end
        if (v_fall) run_sum <= 16'd0;
        if (publish) begin
          frame_sum  <= run_sum;
          frame_cnt  <= frame_cnt + 16'd1;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Synthesizable receive-side monitor for the VGA output of the tangram display path.
- Consumes the hsync/vsync/RGB stream produced by the VGA top level, recovers pixel coordinates, and checks timing against 640x480@60 parameters.
- Produces a per-frame pixel checksum and sticky error flags for self-check and for bench scoreboarding.
- Sits beside the VGA top level, sharing mclk and its pixel-clock enable.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
- mclk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  one-mclk pixel strobe; all sampling happens only when pix_ce=1
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- red, green, blue  in  4 each  pixel colour
- px_valid  out  1  visible pixel captured this cycle
- px_x  out  10  x coordinate of captured pixel, 0..H_VIS-1
- px_y  out  9  y coordinate of captured pixel, 0..V_VIS-1
- px_rgb  out  12  {red,green,blue} of captured pixel
- frame_done  out  1  one-mclk pulse at the vsync falling edge that closes a frame
- frame_sum  out  16  checksum of the last completed frame
- frame_cnt  out  16  completed-frame count; wraps 0xFFFF->0
- locked  out  1  timing lock
- err  out  4  sticky errors: [0] line length, [1] hsync width, [2] frame length, [3] vsync width

Behaviour:
- Reset values (asynchronous): all outputs 0; state HUNT; all counters 0.
- Sampling:
  - Inputs are registered on pix_ce.
  - Edges are detected between consecutive pix_ce samples.
  - Nothing advances when pix_ce=0.
- h_cnt:
  - Cleared to 0 on the hsync falling edge, then incremented per pix_ce; 12-bit, saturates at 4095.
  - On each hsync falling edge, the previous h_cnt+1 is compared with H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
- hsync width: counted while hsync is low and compared with H_SYNC on the rising edge.
- v_cnt:
  - Counts hsync falling edges; cleared on the vsync falling edge.
  - Frame length is compared with V_TOT = 525.
  - vsync width is compared with V_SYNC, measured in lines.
- Visible window:
  - x = h_cnt-(H_SYNC+H_BP), valid for 0..H_VIS-1.
  - y = v_cnt-(V_SYNC+V_BP), valid for 0..V_VIS-1.
  - px_valid is set for 1 mclk, one mclk after the qualifying pix_ce; px_x, px_y and px_rgb are held until the next capture.
- Checksum:
  - Running sum_next = {sum[14:0],sum[15]} XOR zero-extended px_rgb, applied per valid pixel.
  - On the vsync falling edge: frame_sum <= running value, running value <= 0, frame_cnt+1, frame_done pulses.
- State machine:
  - HUNT -> SYNCED on the first vsync falling edge. Errors are not flagged in HUNT, and frame_done/frame_cnt do not fire on this first edge.
  - SYNCED -> LOCKED after LOCK_FRAMES consecutive frames with no mismatch; locked=1 only in LOCKED.
  - Any mismatch in SYNCED resets the clean-frame count.
  - Any mismatch in LOCKED sets the matching err bit, drops locked, and returns to SYNCED.
- err bits are sticky until rst and are only set in SYNCED or LOCKED.
- Simultaneous events:
  - If hsync and vsync fall on the same sample, the hsync edge is processed first (line closes and v_cnt increments), then the vsync edge clears v_cnt.
- px_valid cannot coincide with frame_done, because the visible window excludes sync lines.
- Reset mid-frame returns to HUNT; no partial frame_sum is published.

Test Plan:
- Ideal 640x480 stream, pix_ce every 4th mclk, constant RGB 0x000, 3 frames:
  - locked rises at the 3rd vsync fall (HUNT->SYNCED, then 2 clean frames).
  - err=0; frame_cnt=2; frame_sum=0x0000.
- Single frame, RGB = px_x[3:0] on all channels (0x000,0x111,...):
  - px_valid count = 307200.
  - First capture px_x=0, px_y=0; last capture px_x=639, px_y=479.
  - frame_sum equals the golden model value.
- After lock, emit one 801-pixel line:
  - err[0]=1 and locked=0 at the next hsync fall.
  - locked returns after 2 further clean frames; err[0] stays 1.
- After lock, hsync pulse of 95 pixels: err[1]=1; other err bits 0.
- After lock, vsync held 3 lines and 526-line frame: err[3]=1 and err[2]=1.
- Assert rst for 3 mclk mid-frame (line 200):
  - All outputs 0 immediately.
  - Next vsync fall gives no frame_done and frame_cnt stays 0.
  - The following vsync fall gives frame_cnt=1.
